// File: rtl/ysyx_201979054_axi_lite_line_reader.sv
// AXI4-Lite line reader: fetches one cache line as BEATS single-beat reads at
// consecutive word addresses, one outstanding transaction at a time, and
// assembles the returned words into a line buffer.
module ysyx_201979054_axi_lite_line_reader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     i_start,
  input  logic [ADDR_W-1:0]        i_base_addr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [DATA_W*BEATS-1:0]  o_line,
  output logic [ADDR_W-1:0]        o_araddr,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  input  logic [DATA_W-1:0]        i_rdata,
  input  logic [1:0]               i_rresp,
  input  logic                     i_rvalid,
  output logic                     o_rready
);

  localparam int STRIDE_SH = $clog2(DATA_W / 8);
  localparam int BEAT_W    = $clog2(BEATS);
  localparam int LINE_W    = DATA_W * BEATS;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << STRIDE_SH) - 64'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                resp_err_s;

  // Word address of a given beat; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
    beat_addr = base + (ADDR_W'(beat) << STRIDE_SH);
  endfunction

  // SLVERR (2'b10) and DECERR (2'b11) both mark the line as bad.
  assign resp_err_s = (i_rresp == 2'b10) || (i_rresp == 2'b11);

  // Next-state logic; handshake outputs are derived from the next state so
  // that they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    araddr_d = araddr_q;
    error_d  = error_q;
    line_d   = line_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d   = i_base_addr & ALIGN_MASK;
          araddr_d = i_base_addr & ALIGN_MASK;
          beat_d   = '0;
          error_d  = 1'b0;
          state_d  = S_ADDR;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ADDR: begin
        if (i_arready) begin
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (i_rvalid) begin
          line_d[beat_q*DATA_W +: DATA_W] = i_rdata;
          error_d = error_q | resp_err_s;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d   = beat_q + 1'b1;
            araddr_d = beat_addr(base_q, beat_q + 1'b1);
            state_d  = S_ADDR;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    arvalid_d = (state_d == S_ADDR);
    rready_d  = (state_d == S_DATA);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset that abandons any fill.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      line_q    <= line_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;
  assign o_line    = line_q;
  assign o_araddr  = araddr_q;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;

endmodule

// File: tb/tb_ysyx_201979054_axi_lite_line_reader.sv
// Directed testbench for the AXI4-Lite line reader with a small slave responder.
module tb_ysyx_201979054_axi_lite_line_reader;

  localparam int BEATS = 16;

  logic         clk;
  logic         arst;
  logic         i_start;
  logic [31:0]  i_base_addr;
  logic         o_busy;
  logic         o_done;
  logic         o_error;
  logic [511:0] o_line;
  logic [31:0]  o_araddr;
  logic         o_arvalid;
  logic         i_arready;
  logic [31:0]  i_rdata;
  logic [1:0]   i_rresp;
  logic         i_rvalid;
  logic         o_rready;

  int errors;
  int checks;

  logic [31:0]  ar_log [0:31];
  int           ar_n;
  int           done_n;
  int           done_cyc;
  int           viol;
  int           early;
  logic         err_at_done;
  logic [511:0] line_at_done;

  ysyx_201979054_axi_lite_line_reader dut (
    .clk         (clk),
    .arst        (arst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_line      (o_line),
    .o_araddr    (o_araddr),
    .o_arvalid   (o_arvalid),
    .i_arready   (i_arready),
    .i_rdata     (i_rdata),
    .i_rresp     (i_rresp),
    .i_rvalid    (i_rvalid),
    .o_rready    (o_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one line fill with a slave model; records AR addresses, o_done
  // timing and protocol violations. rst_beat >= 0 asserts arst in that beat's DATA.
  task automatic do_fill(input logic [31:0] base, input int ar_stall, input int r_stall,
                         input logic [31:0] seed, input int err_beat, input bit glitch,
                         input int rst_beat, output bit rst_done);
    int cyc, beat, arw, rw, post;
    bit prev_hs, prev_ar_wait;
    logic [31:0]  prev_addr;
    logic [511:0] prev_line;
    ar_n = 0; done_n = 0; done_cyc = -1; viol = 0; early = 0; rst_done = 1'b0;
    err_at_done = 1'b0; line_at_done = '0;
    i_start = 1'b1;
    i_base_addr = base;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_base_addr = 32'h0;
    cyc = 1; beat = 0; arw = 0; rw = 0; post = 0;
    prev_hs = 1'b1; prev_ar_wait = 1'b0; prev_addr = 32'h0; prev_line = o_line;
    while (cyc < 600) begin
      if (!prev_hs && (o_line !== prev_line)) early++;
      if (prev_ar_wait && (!o_arvalid || (o_araddr !== prev_addr))) viol++;
      if (o_arvalid && o_rready) viol++;
      if (o_done) begin
        done_n++;
        if (done_n == 1) begin
          done_cyc = cyc;
          err_at_done = o_error;
          line_at_done = o_line;
        end
      end
      prev_line = o_line;
      prev_hs = 1'b0;
      prev_ar_wait = 1'b0;
      i_arready = 1'b0;
      i_rvalid = 1'b0;
      i_rresp = 2'b00;
      i_rdata = 32'h0;
      i_start = glitch && o_busy;
      i_base_addr = glitch ? 32'hDEAD_0000 : 32'h0;
      if (o_arvalid) begin
        if (arw == ar_stall) begin
          i_arready = 1'b1;
          if (ar_n < 32) ar_log[ar_n] = o_araddr;
          ar_n++;
          arw = 0;
        end else begin
          arw++;
          prev_ar_wait = 1'b1;
          prev_addr = o_araddr;
        end
      end
      if (o_rready) begin
        if (rst_beat == beat) begin
          arst = 1'b1;
          rst_done = 1'b1;
        end else if (rw == r_stall) begin
          i_rvalid = 1'b1;
          i_rdata = seed + beat;
          i_rresp = (beat == err_beat) ? 2'b10 : 2'b00;
          prev_hs = 1'b1;
          beat++;
          rw = 0;
        end else begin
          rw++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (rst_done) begin
        arst = 1'b0;
        break;
      end
      if (done_n > 0) post++;
      if (post >= 3) break;
    end
    i_start = 1'b0;
    i_base_addr = 32'h0;
    i_arready = 1'b0;
    i_rvalid = 1'b0;
    i_rresp = 2'b00;
    i_rdata = 32'h0;
  endtask

  // Reset values on every output.
  task automatic test_reset();
    arst = 1'b1;
    i_start = 1'b0; i_base_addr = 32'h0; i_arready = 1'b0;
    i_rdata = 32'h0; i_rresp = 2'b00; i_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", o_done); end
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0h exp=0", o_error); end
    checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%0h exp=0", o_arvalid); end
    checks++; if (o_rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%0h exp=0", o_rready); end
    checks++; if (o_araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got=%h exp=0", o_araddr); end
    checks++; if (o_line !== 512'h0) begin errors++; $display("FAIL reset_line got=%h exp=0", o_line); end
    arst = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0h exp=0", o_busy); end
  endtask

  // Zero-wait fill from 0x1000 with data 0xA0+k.
  task automatic test_zero_wait();
    bit rd;
    do_fill(32'h0000_1000, 0, 0, 32'h0000_00A0, -1, 1'b0, -1, rd);
    checks++; if (done_cyc !== 33) begin errors++; $display("FAIL zw_done_cycle got=%0d exp=33", done_cyc); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL zw_done_count got=%0d exp=1", done_n); end
    checks++; if (ar_n !== 16) begin errors++; $display("FAIL zw_ar_count got=%0d exp=16", ar_n); end
    checks++; if (ar_log[0] !== 32'h0000_1000) begin errors++; $display("FAIL zw_ar0 got=%h exp=00001000", ar_log[0]); end
    checks++; if (ar_log[15] !== 32'h0000_103C) begin errors++; $display("FAIL zw_ar15 got=%h exp=0000103c", ar_log[15]); end
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if (ar_log[k] !== (32'h0000_1000 + 32'(4 * k))) begin
        errors++; $display("FAIL zw_ar_%0d got=%h exp=%h", k, ar_log[k], 32'h0000_1000 + 32'(4 * k));
      end
      checks++;
      if (line_at_done[k*32 +: 32] !== (32'h0000_00A0 + 32'(k))) begin
        errors++; $display("FAIL zw_word_%0d got=%h exp=%h", k, line_at_done[k*32 +: 32], 32'h0000_00A0 + 32'(k));
      end
    end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL zw_error got=%0h exp=0", err_at_done); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL zw_protocol got=%0d exp=0", viol); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL zw_busy_after got=%0h exp=0", o_busy); end
  endtask

  // AR stalled 3 cycles and R stalled 2 cycles per beat: 7 cycles per beat.
  task automatic test_backpressure();
    bit rd;
    do_fill(32'h0000_2000, 3, 2, 32'h0000_5500, -1, 1'b0, -1, rd);
    checks++; if (viol !== 0) begin errors++; $display("FAIL bp_ar_stable got=%0d exp=0", viol); end
    checks++; if (early !== 0) begin errors++; $display("FAIL bp_early_capture got=%0d exp=0", early); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_n); end
    checks++; if (done_cyc !== 113) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=113", done_cyc); end
    checks++; if (ar_n !== 16) begin errors++; $display("FAIL bp_ar_count got=%0d exp=16", ar_n); end
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if (line_at_done[k*32 +: 32] !== (32'h0000_5500 + 32'(k))) begin
        errors++; $display("FAIL bp_word_%0d got=%h exp=%h", k, line_at_done[k*32 +: 32], 32'h0000_5500 + 32'(k));
      end
    end
  endtask

  // SLVERR on beat 5 sets sticky error without aborting; next clean fill clears it.
  task automatic test_error();
    bit rd;
    do_fill(32'h0000_3000, 0, 1, 32'h0000_0300, 5, 1'b0, -1, rd);
    checks++; if (ar_n !== 16) begin errors++; $display("FAIL err_ar_count got=%0d exp=16", ar_n); end
    checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL err_at_done got=%0h exp=1", err_at_done); end
    checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_sticky_idle got=%0h exp=1", o_error); end
    checks++; if (line_at_done[15*32 +: 32] !== 32'h0000_030F) begin
      errors++; $display("FAIL err_word15 got=%h exp=0000030f", line_at_done[15*32 +: 32]);
    end
    do_fill(32'h0000_3000, 0, 0, 32'h0000_0400, -1, 1'b0, -1, rd);
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL err_cleared got=%0h exp=0", err_at_done); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL err_done_count got=%0d exp=1", done_n); end
  endtask

  // Unaligned base near the top of the address space wraps to zero.
  task automatic test_wrap();
    bit rd;
    do_fill(32'hFFFF_FFF3, 0, 0, 32'h0000_0000, -1, 1'b0, -1, rd);
    checks++; if (ar_log[0] !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wrap_ar0 got=%h exp=fffffff0", ar_log[0]); end
    checks++; if (ar_log[1] !== 32'hFFFF_FFF4) begin errors++; $display("FAIL wrap_ar1 got=%h exp=fffffff4", ar_log[1]); end
    checks++; if (ar_log[3] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ar3 got=%h exp=fffffffc", ar_log[3]); end
    checks++; if (ar_log[4] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_ar4 got=%h exp=00000000", ar_log[4]); end
    checks++; if (ar_log[15] !== 32'h0000_002C) begin errors++; $display("FAIL wrap_ar15 got=%h exp=0000002c", ar_log[15]); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL wrap_done_count got=%0d exp=1", done_n); end
  endtask

  // Reset during beat 7 DATA abandons the fill; a new fill then completes.
  task automatic test_reset_mid_fill();
    bit rd;
    int extra_done;
    do_fill(32'h0000_6000, 0, 0, 32'h0000_0077, -1, 1'b0, 7, rd);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL rst_reached_beat7 got=%0h exp=1", rd); end
    checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%0h exp=0", o_arvalid); end
    checks++; if (o_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got=%0h exp=0", o_rready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", o_busy); end
    checks++; if (o_line !== 512'h0) begin errors++; $display("FAIL rst_line got=%h exp=0", o_line); end
    extra_done = done_n;
    for (int i = 0; i < 5; i++) begin
      if (o_done) extra_done++;
      @(posedge clk); #1;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", extra_done); end
    do_fill(32'h0000_4000, 0, 0, 32'h0000_0010, -1, 1'b0, -1, rd);
    checks++; if (done_cyc !== 33) begin errors++; $display("FAIL rst_refill_cycle got=%0d exp=33", done_cyc); end
    checks++; if (line_at_done[7*32 +: 32] !== 32'h0000_0017) begin
      errors++; $display("FAIL rst_refill_word7 got=%h exp=00000017", line_at_done[7*32 +: 32]);
    end
    checks++; if (ar_log[15] !== 32'h0000_403C) begin errors++; $display("FAIL rst_refill_ar15 got=%h exp=0000403c", ar_log[15]); end
  endtask

  // i_start held high with another base throughout ADDR, DATA and DONE.
  task automatic test_start_while_busy();
    bit rd;
    do_fill(32'h0000_5000, 1, 0, 32'h0000_0900, -1, 1'b1, -1, rd);
    checks++; if (done_n !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", done_n); end
    checks++; if (ar_n !== 16) begin errors++; $display("FAIL busy_ar_count got=%0d exp=16", ar_n); end
    checks++; if (ar_log[0] !== 32'h0000_5000) begin errors++; $display("FAIL busy_ar0 got=%h exp=00005000", ar_log[0]); end
    checks++; if (ar_log[9] !== 32'h0000_5024) begin errors++; $display("FAIL busy_ar9 got=%h exp=00005024", ar_log[9]); end
    checks++; if (ar_log[15] !== 32'h0000_503C) begin errors++; $display("FAIL busy_ar15 got=%h exp=0000503c", ar_log[15]); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after got=%0h exp=0", o_busy); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_error();
    test_wrap();
    test_reset_mid_fill();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
